// File: rtl/uart_parity_core.sv
// uart_parity_core: 16x-oversampled UART with runtime parity (none/even/odd)
// and per-byte error tags.
// RX: frames go into a first-word-fall-through FIFO as {ferr, perr, data}.
//     A push while the FIFO is full sets the sticky overrun flag.
// TX: takes words through a valid/ready handshake.
// Optional feature macro: UART_BREAK_DETECT_EN. When it is defined, a break
// frame pulses rx_break and is not stored in the FIFO.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   parity_mode[1:0]       00 none, 01 even, 10 odd, 11 none
//   rx / tx                serial in (already synchronised) / serial out, idle high
//   tx_data/valid/ready    transmit handshake
//   rd_uart                pop the RX FIFO head
//   rx_empty, rx_full      RX FIFO status
//   r_data/r_perr/r_ferr   RX FIFO head word and its error tags
//   overrun, clr_overrun   sticky dropped-word flag and its clear
//   rx_break               one-cycle break pulse (tied to 0 unless the macro is set)
module uart_parity_core #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 163,
  parameter int DVSR_BIT = 8,
  parameter int FIFO_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      parity_mode,
  input  logic            rx,
  output logic            tx,
  input  logic [DBIT-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic            rd_uart,
  output logic            rx_empty,
  output logic            rx_full,
  output logic [DBIT-1:0] r_data,
  output logic            r_perr,
  output logic            r_ferr,
  output logic            overrun,
  input  logic            clr_overrun,
  output logic            rx_break
);
  localparam int SW    = $clog2(SB_TICK + 1);
  localparam int NW    = $clog2(DBIT + 1);
  localparam int DEPTH = 1 << FIFO_W;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic par_en(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  // baud tick generator
  logic [DVSR_BIT-1:0] cnt_q;
  logic                tick;
  assign tick = (cnt_q == DVSR_BIT'(DVSR - 1));
  always_ff @(posedge clk) begin
    if (reset || tick) cnt_q <= '0;
    else               cnt_q <= cnt_q + DVSR_BIT'(1);
  end

  // receiver
  state_e          rx_st_q, rx_st_d;
  logic [SW-1:0]   rx_s_q, rx_s_d;
  logic [NW-1:0]   rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic            rx_p_q, rx_p_d;
  logic [1:0]      rx_mode_q, rx_mode_d;
  logic            push, perr_c, ferr_c;
`ifdef UART_BREAK_DETECT_EN
  logic            brk_hold_q, brk_hold_d, brk_det, rx_break_q;
`endif

  always_comb begin
    perr_c = 1'b0;
    if (rx_mode_q == 2'b01)      perr_c = ^{rx_b_q, rx_p_q};
    else if (rx_mode_q == 2'b10) perr_c = ~^{rx_b_q, rx_p_q};
  end
  assign ferr_c = ~rx;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_s_d    = rx_s_q;
    rx_n_d    = rx_n_q;
    rx_b_d    = rx_b_q;
    rx_p_d    = rx_p_q;
    rx_mode_d = rx_mode_q;
    push      = 1'b0;
`ifdef UART_BREAK_DETECT_EN
    brk_hold_d = brk_hold_q;
    brk_det    = 1'b0;
`endif
    case (rx_st_q)
      S_IDLE: begin
`ifdef UART_BREAK_DETECT_EN
        // after a break, wait for one full 16-tick period of idle line
        if (brk_hold_q) begin
          if (!rx) rx_s_d = '0;
          else if (tick) begin
            if (rx_s_q == SW'(15)) begin
              brk_hold_d = 1'b0;
              rx_s_d     = '0;
            end else rx_s_d = rx_s_q + SW'(1);
          end
        end else
`endif
        if (!rx) begin
          rx_st_d   = S_START;
          rx_s_d    = '0;
          rx_p_d    = 1'b0;
          rx_mode_d = parity_mode;
        end
      end
      S_START: if (tick) begin
        if (rx_s_q == SW'(7)) begin
          rx_s_d  = '0;
          rx_n_d  = '0;
          rx_st_d = rx ? S_IDLE : S_DATA;
        end else rx_s_d = rx_s_q + SW'(1);
      end
      S_DATA: if (tick) begin
        if (rx_s_q == SW'(15)) begin
          rx_s_d = '0;
          rx_b_d = {rx, rx_b_q[DBIT-1:1]};
          if (rx_n_q == NW'(DBIT - 1)) rx_st_d = par_en(rx_mode_q) ? S_PARITY : S_STOP;
          else                         rx_n_d  = rx_n_q + NW'(1);
        end else rx_s_d = rx_s_q + SW'(1);
      end
      S_PARITY: if (tick) begin
        if (rx_s_q == SW'(15)) begin
          rx_s_d  = '0;
          rx_p_d  = rx;
          rx_st_d = S_STOP;
        end else rx_s_d = rx_s_q + SW'(1);
      end
      S_STOP: if (tick) begin
        if (rx_s_q == SW'(SB_TICK - 1)) begin
          rx_st_d = S_IDLE;
          rx_s_d  = '0;
`ifdef UART_BREAK_DETECT_EN
          if (rx_b_q == '0 && !rx && !(par_en(rx_mode_q) && rx_p_q)) begin
            brk_det    = 1'b1;
            brk_hold_d = 1'b1;
          end else
`endif
          push = 1'b1;
        end else rx_s_d = rx_s_q + SW'(1);
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st_q   <= S_IDLE;
      rx_s_q    <= '0;
      rx_n_q    <= '0;
      rx_b_q    <= '0;
      rx_p_q    <= 1'b0;
      rx_mode_q <= '0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_s_q    <= rx_s_d;
      rx_n_q    <= rx_n_d;
      rx_b_q    <= rx_b_d;
      rx_p_q    <= rx_p_d;
      rx_mode_q <= rx_mode_d;
    end
  end

`ifdef UART_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      brk_hold_q <= 1'b0;
      rx_break_q <= 1'b0;
    end else begin
      brk_hold_q <= brk_hold_d;
      rx_break_q <= brk_det;
    end
  end
  assign rx_break = rx_break_q;
`else
  assign rx_break = 1'b0;
`endif

  // RX FIFO, first-word-fall-through
  logic [DBIT+1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] wr_q, rd_q;
  logic [FIFO_W:0]   fcnt_q;
  logic              do_push, do_pop, ovr_set, overrun_q;

  assign rx_empty = (fcnt_q == '0);
  assign rx_full  = (fcnt_q == (FIFO_W + 1)'(DEPTH));
  assign do_pop   = rd_uart && !rx_empty;
  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign do_push  = push && (!rx_full || do_pop);
  assign ovr_set  = push && rx_full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= {ferr_c, perr_c, rx_b_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      fcnt_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + FIFO_W'(1);
      if (do_pop)  rd_q <= rd_q + FIFO_W'(1);
      case ({do_push, do_pop})
        2'b10:   fcnt_q <= fcnt_q + (FIFO_W + 1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (FIFO_W + 1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (ovr_set)          overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
    end
  end

  assign overrun = overrun_q;
  assign {r_ferr, r_perr, r_data} = mem[rd_q];

  // transmitter
  state_e          tx_st_q, tx_st_d;
  logic [SW-1:0]   tx_s_q, tx_s_d;
  logic [NW-1:0]   tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_sh_q, tx_sh_d;
  logic            tx_pb_q, tx_pb_d, tx_pen_q, tx_pen_d;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_s_d   = tx_s_q;
    tx_n_d   = tx_n_q;
    tx_sh_d  = tx_sh_q;
    tx_pb_d  = tx_pb_q;
    tx_pen_d = tx_pen_q;
    tx       = 1'b1;
    tx_ready = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          tx_sh_d  = tx_data;
          // parity bit fixed at accept; the shift register is consumed later
          tx_pb_d  = (parity_mode == 2'b10) ? ~^tx_data : ^tx_data;
          tx_pen_d = par_en(parity_mode);
          tx_s_d   = '0;
          tx_st_d  = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (tick) begin
          if (tx_s_q == SW'(15)) begin
            tx_s_d  = '0;
            tx_n_d  = '0;
            tx_st_d = S_DATA;
          end else tx_s_d = tx_s_q + SW'(1);
        end
      end
      S_DATA: begin
        tx = tx_sh_q[0];
        if (tick) begin
          if (tx_s_q == SW'(15)) begin
            tx_s_d  = '0;
            tx_sh_d = {1'b0, tx_sh_q[DBIT-1:1]};
            if (tx_n_q == NW'(DBIT - 1)) tx_st_d = tx_pen_q ? S_PARITY : S_STOP;
            else                         tx_n_d  = tx_n_q + NW'(1);
          end else tx_s_d = tx_s_q + SW'(1);
        end
      end
      S_PARITY: begin
        tx = tx_pb_q;
        if (tick) begin
          if (tx_s_q == SW'(15)) begin
            tx_s_d  = '0;
            tx_st_d = S_STOP;
          end else tx_s_d = tx_s_q + SW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tx_s_q == SW'(SB_TICK - 1)) tx_st_d = S_IDLE;
          else                            tx_s_d  = tx_s_q + SW'(1);
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q  <= S_IDLE;
      tx_s_q   <= '0;
      tx_n_q   <= '0;
      tx_sh_q  <= '0;
      tx_pb_q  <= 1'b0;
      tx_pen_q <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_s_q   <= tx_s_d;
      tx_n_q   <= tx_n_d;
      tx_sh_q  <= tx_sh_d;
      tx_pb_q  <= tx_pb_d;
      tx_pen_q <= tx_pen_d;
    end
  end
endmodule

// File: tb/tb_uart_parity_core.sv
// Self-checking bench for uart_parity_core (DVSR=4, DBIT=8, FIFO_W=2).
// rx is the AND of a bench-driven line and tx, so an idle bench line gives
// tx->rx loopback.
module tb_uart_parity_core;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] parity_mode = 2'b00;
  logic       rx_drv = 1'b1;
  logic       rx;
  logic       tx;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       rd_uart = 1'b0;
  logic       rx_empty, rx_full;
  logic [7:0] r_data;
  logic       r_perr, r_ferr;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       rx_break;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int brk_cnt = 0;

  assign rx = rx_drv & tx;

  uart_parity_core #(
    .DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_BIT(8), .FIFO_W(2)
  ) dut (
    .clk(clk), .reset(reset), .parity_mode(parity_mode), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rd_uart(rd_uart), .rx_empty(rx_empty), .rx_full(rx_full),
    .r_data(r_data), .r_perr(r_perr), .r_ferr(r_ferr),
    .overrun(overrun), .clr_overrun(clr_overrun), .rx_break(rx_break)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_break) brk_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (failure %0d)", tag, obs, exp, fails);
    end
  endtask

  // reference rules
  function automatic logic has_par(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  // bit that makes the total count of ones even (01) or odd (10)
  function automatic logic exp_txpar(input logic [1:0] m, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    if (m == 2'b10) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic logic exp_perr(input logic [1:0] m, input logic [7:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    if (m == 2'b01) return (ones % 2) == 1;
    if (m == 2'b10) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  // 64 clk per bit; a bad stop bit is held low only briefly so the trailing
  // low level is rejected as a glitch
  task automatic drive_frame(input logic [7:0] d, input logic par, input logic pbit,
                             input logic stop_ok);
    rx_drv = 1'b0;
    cyc(64);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      cyc(64);
    end
    if (par) begin
      rx_drv = pbit;
      cyc(64);
    end
    rx_drv = stop_ok;
    cyc(stop_ok ? 64 : 40);
    rx_drv = 1'b1;
    cyc(80);
  endtask

  task automatic pop();
    rd_uart = 1'b1;
    cyc(1);
    rd_uart = 1'b0;
  endtask

  task automatic wait_head(input string tag);
    int n;
    n = 0;
    while (rx_empty && n < 2000) begin
      cyc(1);
      n++;
    end
    check({tag, "_wait"}, rx_empty, 1'b0);
  endtask

  task automatic check_head_pop(input string tag, input logic [7:0] d, input logic pe,
                                input logic fe);
    wait_head(tag);
    check({tag, "_data"}, r_data, d);
    check({tag, "_perr"}, r_perr, pe);
    check({tag, "_ferr"}, r_ferr, fe);
    pop();
  endtask

  task automatic send_tx(input logic [7:0] d, input logic [1:0] m);
    logic [7:0] got;
    int k, t;
    got = '0;
    parity_mode = m;
    tx_data = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    check("tx_ready_fall", tx_ready, 1'b0);
    check("tx_start_low", tx, 1'b0);
    cyc(32);
    k = 32;
    for (int i = 0; i < 8; i++) begin
      cyc(64);
      k += 64;
      got[i] = tx;
    end
    if (has_par(m)) begin
      cyc(64);
      k += 64;
      check("tx_parity_bit", tx, exp_txpar(m, d));
    end
    cyc(64);
    k += 64;
    check("tx_stop_bit", tx, 1'b1);
    check("tx_word", got, d);
    while (!tx_ready && k < 2000) begin
      cyc(1);
      k++;
    end
    t = 16 * (9 + int'(has_par(m))) + 16;
    check("tx_frame_len", (k >= 4 * (t - 1) + 1) && (k <= 4 * (t - 1) + 4), 1'b1);
    check_head_pop("loop", d, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    logic [1:0] m;
    logic       pbit, stop_ok;
    int         b0;

    // reset
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_full", rx_full, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_rx_break", rx_break, 1'b0);

    // even-parity loopback
    send_tx(8'hA5, 2'b01);

    // odd parity, wrong parity bit
    parity_mode = 2'b10;
    drive_frame(8'h01, 1'b1, 1'b1, 1'b1);
    check_head_pop("odd_err", 8'h01, exp_perr(2'b10, 8'h01, 1'b1), 1'b0);

    // framing error
    parity_mode = 2'b00;
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_head_pop("frame_err", 8'h3C, 1'b0, 1'b1);

    // pop while empty is ignored
    pop();
    check("empty_pop_empty", rx_empty, 1'b1);
    check("empty_pop_full", rx_full, 1'b0);

    // overrun: five frames into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h50 + i * 8'h11);
      drive_frame(d, 1'b0, 1'b0, 1'b1);
      if (q.size() < 4) q.push_back(d);
      if (i == 3) begin
        check("ovr_full4", rx_full, 1'b1);
        check("ovr_not_yet", overrun, 1'b0);
      end
    end
    check("ovr_full5", rx_full, 1'b1);
    check("ovr_set", overrun, 1'b1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    check("ovr_clr", overrun, 1'b0);
    while (q.size() > 0) begin
      d = q.pop_front();
      check_head_pop("ovr_word", d, 1'b0, 1'b0);
    end
    check("ovr_drained", rx_empty, 1'b1);

    // glitch: 4-tick low pulse
    rx_drv = 1'b0;
    cyc(16);
    rx_drv = 1'b1;
    cyc(300);
    check("glitch_no_push", rx_empty, 1'b1);

    // break frame
    parity_mode = 2'b00;
    b0 = brk_cnt;
    drive_frame(8'h00, 1'b0, 1'b0, 1'b0);
    cyc(20);
`ifdef UART_BREAK_DETECT_EN
    check("break_pulses", brk_cnt - b0, 1);
    check("break_no_push", rx_empty, 1'b1);
`else
    check("break_pulses", brk_cnt - b0, 0);
    check_head_pop("break_word", 8'h00, 1'b0, 1'b1);
`endif

    // randomized received frames
    for (int r = 0; r < 6; r++) begin
      m = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      if (d == 8'h00) stop_ok = 1'b1;
      pbit = has_par(m) ? (exp_txpar(m, d) ^ 1'($urandom_range(0, 1))) : 1'b0;
      parity_mode = m;
      drive_frame(d, has_par(m), pbit, stop_ok);
      check_head_pop("rand_rx", d, exp_perr(m, d, pbit), !stop_ok);
    end

    // randomized loopback frames
    for (int r = 0; r < 3; r++) begin
      send_tx(8'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
